// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch address generator with stall, absolute
// jump, PC-relative branch and call/return through a small LIFO return stack.
// All outputs are registered except stack_full/stack_empty, which decode the
// registered occupancy count.

module pc_sequencer #(
    parameter int AW         = 6,
    parameter int STEP       = 1,
    parameter int RESET_ADDR = 0,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         ret,
    input  logic                         call,
    input  logic                         jump,
    input  logic                         branch,
    input  logic [AW-1:0]                target,
    input  logic [AW-1:0]                offset,
    output logic [AW-1:0]                pc,
    output logic                         pc_valid,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         stack_err
);

    localparam int DW = $clog2(DEPTH + 1);

    // The stack is sized to the full range of the depth counter so that the
    // counter itself can index it without any width conversion. Only entries
    // below DEPTH are ever written.
    localparam int SLOTS = 1 << DW;

    localparam logic [AW-1:0] STEP_V  = AW'(STEP);
    localparam logic [AW-1:0] RESET_V = AW'(RESET_ADDR);
    localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);
    localparam logic [DW-1:0] ONE_D   = DW'(1);

    logic [AW-1:0] stack [SLOTS];

    logic [AW-1:0] pc_seq;
    logic [AW-1:0] pc_rel;
    logic [DW-1:0] top_idx;
    logic          can_push;
    logic          can_pop;

    // Candidate addresses and stack-state qualifiers, all AW-bit wrap-around.
    always_comb begin
        pc_seq   = pc + STEP_V;
        pc_rel   = pc + offset;
        top_idx  = depth - ONE_D;
        can_push = (depth != DEPTH_V);
        can_pop  = (depth != '0);
    end

    // Occupancy decode; the only outputs not taken straight from a register.
    always_comb begin
        stack_full  = (depth == DEPTH_V);
        stack_empty = (depth == '0);
    end

    // Main sequencer: reset wins, stall holds everything, otherwise exactly
    // one action per edge in the order ret > call > jump > branch > step.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_V;
            pc_valid  <= 1'b0;
            depth     <= '0;
            stack_err <= 1'b0;
        end else begin
            pc_valid <= 1'b1;
            if (en) begin
                if (ret) begin
                    if (can_pop) begin
                        pc    <= stack[top_idx];
                        depth <= top_idx;
                    end else begin
                        pc        <= pc_seq;
                        stack_err <= 1'b1;
                    end
                end else if (call) begin
                    if (can_push) begin
                        pc    <= target;
                        depth <= depth + ONE_D;
                    end else begin
                        pc        <= pc_seq;
                        stack_err <= 1'b1;
                    end
                end else if (jump) begin
                    pc <= target;
                end else if (branch) begin
                    pc <= pc_rel;
                end else begin
                    pc <= pc_seq;
                end
            end
        end
    end

    // Return-address storage: a successful call writes the slot just above
    // the current top. Contents need no reset because depth guards every read.
    always_ff @(posedge clk) begin
        if (!reset && en && !ret && call && can_push) begin
            stack[depth] <= pc_seq;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with default parameters
// (AW=6, STEP=1, RESET_ADDR=0, DEPTH=4).

module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic       en;
    logic       ret;
    logic       call;
    logic       jump;
    logic       branch;
    logic [5:0] target;
    logic [5:0] offset;
    logic [5:0] pc;
    logic       pc_valid;
    logic [2:0] depth;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic       ret;
        logic       call;
        logic       jump;
        logic       branch;
        logic [5:0] target;
        logic [5:0] offset;
        logic [5:0] exp_pc;
        logic       exp_valid;
        logic [2:0] exp_depth;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .ret         (ret),
        .call        (call),
        .jump        (jump),
        .branch      (branch),
        .target      (target),
        .offset      (offset),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic addVec(input string name, input logic r, input logic e,
                          input logic rt, input logic c, input logic j,
                          input logic b, input logic [5:0] t,
                          input logic [5:0] o, input logic [5:0] xpc,
                          input logic xv, input logic [2:0] xd,
                          input logic xe);
        vec_t v;
        v.name = name;  v.rst = r;  v.en = e;  v.ret = rt;  v.call = c;
        v.jump = j;  v.branch = b;  v.target = t;  v.offset = o;
        v.exp_pc = xpc;  v.exp_valid = xv;  v.exp_depth = xd;  v.exp_err = xe;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, let the edge happen, then step off the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic rt,
                                 input logic c, input logic j, input logic b,
                                 input logic [5:0] t, input logic [5:0] o);
        reset = r;  en = e;  ret = rt;  call = c;  jump = j;  branch = b;
        target = t;  offset = o;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] xpc,
                               input logic xv, input logic [2:0] xd,
                               input logic xe);
        logic xf;
        logic xm;
        xf = (xd == 3'd4);
        xm = (xd == 3'd0);
        total++;
        if (pc !== xpc || pc_valid !== xv || depth !== xd ||
            stack_full !== xf || stack_empty !== xm || stack_err !== xe) begin
            bad++;
            $display("[TB] FAIL %s: got pc=%0d valid=%0b depth=%0d full=%0b empty=%0b err=%0b, want pc=%0d valid=%0b depth=%0d full=%0b empty=%0b err=%0b",
                     name, pc, pc_valid, depth, stack_full, stack_empty, stack_err,
                     xpc, xv, xd, xf, xm, xe);
        end
    endtask

    initial begin
        reset = 1'b1;  en = 1'b0;  ret = 1'b0;  call = 1'b0;
        jump = 1'b0;  branch = 1'b0;  target = '0;  offset = '0;

        //      name         rst en ret cal jmp br  tgt off    pc  v  d  err
        addVec("rst0",       1, 1, 0, 0, 0, 0,  0,  0,     0, 0, 0, 0);
        addVec("rst1",       1, 1, 0, 0, 0, 0,  0,  0,     0, 0, 0, 0);
        addVec("seq1",       0, 1, 0, 0, 0, 0,  0,  0,     1, 1, 0, 0);
        addVec("seq2",       0, 1, 0, 0, 0, 0,  0,  0,     2, 1, 0, 0);
        addVec("seq3",       0, 1, 0, 0, 0, 0,  0,  0,     3, 1, 0, 0);
        addVec("seq4",       0, 1, 0, 0, 0, 0,  0,  0,     4, 1, 0, 0);
        addVec("seq5",       0, 1, 0, 0, 0, 0,  0,  0,     5, 1, 0, 0);
        addVec("stall0",     0, 0, 0, 1, 0, 0, 20,  0,     5, 1, 0, 0);
        addVec("stall1",     0, 0, 0, 1, 0, 0, 20,  0,     5, 1, 0, 0);
        addVec("stall2",     0, 0, 0, 1, 0, 0, 20,  0,     5, 1, 0, 0);
        addVec("release",    0, 1, 0, 0, 0, 0,  0,  0,     6, 1, 0, 0);
        addVec("seq7",       0, 1, 0, 0, 0, 0,  0,  0,     7, 1, 0, 0);
        addVec("seq8",       0, 1, 0, 0, 0, 0,  0,  0,     8, 1, 0, 0);
        addVec("seq9",       0, 1, 0, 0, 0, 0,  0,  0,     9, 1, 0, 0);
        addVec("seq10",      0, 1, 0, 0, 0, 0,  0,  0,    10, 1, 0, 0);
        addVec("jump40",     0, 1, 0, 0, 1, 0, 40,  0,    40, 1, 0, 0);
        addVec("br_neg4",    0, 1, 0, 0, 0, 1,  0, 60,    36, 1, 0, 0);
        addVec("br_wrap",    0, 1, 0, 0, 0, 1,  0, 30,     2, 1, 0, 0);
        addVec("seq_to3",    0, 1, 0, 0, 0, 0,  0,  0,     3, 1, 0, 0);
        addVec("call20",     0, 1, 0, 1, 0, 0, 20,  0,    20, 1, 1, 0);
        addVec("call50",     0, 1, 0, 1, 0, 0, 50,  0,    50, 1, 2, 0);
        addVec("ret21",      0, 1, 1, 0, 0, 0,  0,  0,    21, 1, 1, 0);
        addVec("ret4",       0, 1, 1, 0, 0, 0,  0,  0,     4, 1, 0, 0);
        addVec("br_zero",    0, 1, 0, 0, 0, 1,  0,  0,     4, 1, 0, 0);
        addVec("seq_to5",    0, 1, 0, 0, 0, 0,  0,  0,     5, 1, 0, 0);
        addVec("seq_to6",    0, 1, 0, 0, 0, 0,  0,  0,     6, 1, 0, 0);
        addVec("call30",     0, 1, 0, 1, 0, 0, 30,  0,    30, 1, 1, 0);
        addVec("prio_rcj",   0, 1, 1, 1, 1, 0, 12,  0,     7, 1, 0, 0);
        addVec("prio_jb",    0, 1, 0, 0, 1, 1, 11,  5,    11, 1, 0, 0);
        addVec("prio_cj",    0, 1, 0, 1, 1, 0, 15,  0,    15, 1, 1, 0);
        addVec("ret12",      0, 1, 1, 0, 0, 0,  0,  0,    12, 1, 0, 0);
        addVec("ovf_c1",     0, 1, 0, 1, 0, 0, 40,  0,    40, 1, 1, 0);
        addVec("ovf_c2",     0, 1, 0, 1, 0, 0, 41,  0,    41, 1, 2, 0);
        addVec("ovf_c3",     0, 1, 0, 1, 0, 0, 42,  0,    42, 1, 3, 0);
        addVec("ovf_c4",     0, 1, 0, 1, 0, 0, 43,  0,    43, 1, 4, 0);
        addVec("ovf_c5",     0, 1, 0, 1, 0, 0,  9,  0,    44, 1, 4, 1);
        addVec("pop_to3",    0, 1, 1, 0, 0, 0,  0,  0,    43, 1, 3, 1);
        addVec("pop_to2",    0, 1, 1, 0, 0, 0,  0,  0,    42, 1, 2, 1);
        addVec("pop_to1",    0, 1, 1, 0, 0, 0,  0,  0,    41, 1, 1, 1);
        addVec("pop_to0",    0, 1, 1, 0, 0, 0,  0,  0,    13, 1, 0, 1);
        addVec("underflow",  0, 1, 1, 0, 0, 0,  0,  0,    14, 1, 0, 1);
        addVec("stall_ret",  0, 0, 1, 0, 0, 0,  0,  0,    14, 1, 0, 1);
        addVec("rc_call1",   0, 1, 0, 1, 0, 0, 20,  0,    20, 1, 1, 1);
        addVec("rc_call2",   0, 1, 0, 1, 0, 0, 30,  0,    30, 1, 2, 1);
        addVec("mid_reset",  1, 1, 0, 1, 0, 0,  5,  0,     0, 0, 0, 0);
        addVec("post_reset", 0, 1, 0, 0, 0, 0,  0,  0,     1, 1, 0, 0);

        $display("[TB] applying %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].ret, vecs[i].call,
                          vecs[i].jump, vecs[i].branch, vecs[i].target,
                          vecs[i].offset);
            checkOutput(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_valid,
                        vecs[i].exp_depth, vecs[i].exp_err);
        end

        // Free-run from pc=1 up to the top of the address space, then wrap.
        for (int i = 2; i <= 63; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 6'd0, 6'd0);
        end
        checkOutput("run_to63", 6'd63, 1'b1, 3'd0, 1'b0);
        applyStimulus(0, 1, 0, 0, 0, 0, 6'd0, 6'd0);
        checkOutput("wrap_to0", 6'd0, 1'b1, 3'd0, 1'b0);

        // Return the stack's top entry after a push made while wrapping:
        // call from pc=63 must save address 0.
        for (int i = 1; i <= 63; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 6'd0, 6'd0);
        end
        checkOutput("again63", 6'd63, 1'b1, 3'd0, 1'b0);
        applyStimulus(0, 1, 0, 1, 0, 0, 6'd33, 6'd0);
        checkOutput("call_wrap", 6'd33, 1'b1, 3'd1, 1'b0);
        applyStimulus(0, 1, 1, 0, 0, 0, 6'd0, 6'd0);
        checkOutput("ret_wrap", 6'd0, 1'b1, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
